// File: rtl/mult_pkg.sv
// Shared definitions for the chunked multiplier sequencer: state encoding and
// the width helper used to size chunk, shift and step selects.
package mult_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'b000,
    ST_CLEAR = 3'b001,
    ST_CALC  = 3'b010,
    ST_DONE  = 3'b011,
    ST_ERR   = 3'b100
  } state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_control_seq_if.sv
// Control/handshake bundle between the multiplier sequencer and its datapath.
interface mult_control_seq_if #(
  parameter int unsigned NCHUNK = 2
);
  import mult_pkg::*;

  localparam int unsigned SELW = clog2_min1(NCHUNK);
  localparam int unsigned SHW  = clog2_min1(2 * NCHUNK - 1);
  localparam int unsigned CNTW = clog2_min1(NCHUNK * NCHUNK);

  logic               start;
  logic               done;
  logic               busy;
  logic               err;
  logic               clk_ena;
  logic               sclr_n;
  logic [SELW-1:0]    sel_a;
  logic [SELW-1:0]    sel_b;
  logic [SHW-1:0]     shift_sel;
  logic [CNTW-1:0]    pp_idx;
  logic [STATE_W-1:0] state_out;

  modport master (
    output start,
    input  done, busy, err, clk_ena, sclr_n,
    input  sel_a, sel_b, shift_sel, pp_idx, state_out
  );

  modport slave (
    input  start,
    output done, busy, err, clk_ena, sclr_n,
    output sel_a, sel_b, shift_sel, pp_idx, state_out
  );

endinterface

// File: rtl/mult_pp_sequencer.sv
// Nested chunk counter: walks all NCHUNK*NCHUNK partial products, A chunk
// in the inner loop and B chunk in the outer loop.
module mult_pp_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned NCHUNK = 2,
  parameter int unsigned SELW   = clog2_min1(NCHUNK),
  parameter int unsigned SHW    = clog2_min1(2 * NCHUNK - 1),
  parameter int unsigned CNTW   = clog2_min1(NCHUNK * NCHUNK)
) (
  input  logic            clk,
  input  logic            reset_a,
  input  logic            clr,
  input  logic            inc,
  output logic [SELW-1:0] sel_a,
  output logic [SELW-1:0] sel_b,
  output logic [SHW-1:0]  shift_sel,
  output logic [CNTW-1:0] pp_idx,
  output logic            last
);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SELW-1:0] a_w, b_w;

  assign last = (cnt_q == CNTW'(NCHUNK * NCHUNK - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    a_w = SELW'(cnt_q % CNTW'(NCHUNK));
    b_w = SELW'(cnt_q / CNTW'(NCHUNK));
  end

  assign sel_a     = a_w;
  assign sel_b     = b_w;
  assign shift_sel = SHW'(a_w) + SHW'(b_w);
  assign pp_idx    = cnt_q;

endmodule

// File: rtl/mult_control_seq.sv
// Sequencing controller for a chunked shift-and-add multiplier: state register
// plus Moore output decode around the partial-product step counter.
module mult_control_seq
  import mult_pkg::*;
#(
  parameter int unsigned NCHUNK  = 2,
  parameter int unsigned CHUNK_W = 4
) (
  input logic              clk,
  input logic              reset_a,
  mult_control_seq_if.slave bus
);

  localparam int unsigned SELW = clog2_min1(NCHUNK);
  localparam int unsigned SHW  = clog2_min1(2 * NCHUNK - 1);
  localparam int unsigned CNTW = clog2_min1(NCHUNK * NCHUNK);

  if (NCHUNK < 1 || CHUNK_W < 1) begin : g_param_check
    $error("mult_control_seq: NCHUNK and CHUNK_W must be >= 1");
  end

  state_t          state_q, state_d;
  logic            seq_clr, seq_inc, seq_last;
  logic [SELW-1:0] seq_sel_a, seq_sel_b;
  logic [SHW-1:0]  seq_shift;
  logic [CNTW-1:0] seq_idx;

  mult_pp_sequencer #(
    .NCHUNK (NCHUNK),
    .SELW   (SELW),
    .SHW    (SHW),
    .CNTW   (CNTW)
  ) u_seq (
    .clk       (clk),
    .reset_a   (reset_a),
    .clr       (seq_clr),
    .inc       (seq_inc),
    .sel_a     (seq_sel_a),
    .sel_b     (seq_sel_b),
    .shift_sel (seq_shift),
    .pp_idx    (seq_idx),
    .last      (seq_last)
  );

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start only steers next state and counter control; outputs use state_q alone.
  always_comb begin
    state_d = state_q;
    seq_clr = 1'b0;
    seq_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        seq_clr = 1'b1;
        state_d = bus.start ? ST_ERR : ST_CALC;
      end
      ST_CALC: begin
        if (bus.start) begin
          seq_clr = 1'b1;
          state_d = ST_ERR;
        end else begin
          seq_inc = 1'b1;
          if (seq_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = bus.start ? ST_CLEAR : ST_IDLE;
      end
      ST_ERR: begin
        if (bus.start) state_d = ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.done      = (state_q == ST_DONE);
    bus.busy      = (state_q == ST_CLEAR) || (state_q == ST_CALC);
    bus.err       = (state_q == ST_ERR);
    bus.clk_ena   = (state_q == ST_CLEAR) || (state_q == ST_CALC);
    bus.sclr_n    = (state_q != ST_CLEAR);
    bus.sel_a     = '0;
    bus.sel_b     = '0;
    bus.shift_sel = '0;
    bus.pp_idx    = '0;
    if (state_q == ST_CALC) begin
      bus.sel_a     = seq_sel_a;
      bus.sel_b     = seq_sel_b;
      bus.shift_sel = seq_shift;
      bus.pp_idx    = seq_idx;
    end
    bus.state_out = state_q;
  end

endmodule

// File: doc/mult_control_seq.md
Name: mult_control_seq

Overview:
- Parametrised sequencing controller for a chunked shift-and-add multiplier of WIDTH = NCHUNK*CHUNK_W bits per operand.
- Drives one CHUNK_W x CHUNK_W multiplier, the operand-chunk muxes, the product shifter and the accumulator enable/clear.
- Generates all NCHUNK*NCHUNK partial-product steps from an internal counter; no external count input.
- Supports back-to-back restart from DONE and abort-to-error on an illegal start.

Parameters:
- NCHUNK, 2, chunks per operand (>=1); partial products = NCHUNK*NCHUNK.
- CHUNK_W, 4, chunk width in bits; informational only, used by datapath shift = shift_sel*CHUNK_W.
- SELW, max(1,$clog2(NCHUNK)), derived; chunk select width.
- SHW, max(1,$clog2(2*NCHUNK-1)), derived; shift select width.
- CNTW, max(1,$clog2(NCHUNK*NCHUNK)), derived; step counter width.

Ports:
- clk  in  1  clock.
- reset_a  in  1  asynchronous, active-low reset.
- start  in  1  synchronous start request, sampled on clk rising edge.
- done  out  1  one-cycle pulse: product valid in accumulator.
- busy  out  1  high in CLEAR and CALC.
- err  out  1  high while in ERR.
- clk_ena  out  1  accumulator/datapath register enable.
- sclr_n  out  1  accumulator synchronous clear, active low.
- sel_a  out  SELW  operand A chunk select.
- sel_b  out  SELW  operand B chunk select.
- shift_sel  out  SHW  partial-product shift in chunks (sel_a+sel_b).
- pp_idx  out  CNTW  current step index.
- state_out  out  3  current state encoding.

Behaviour:
- Reset: asynchronous on reset_a low. state=IDLE, counter=0.
- Reset values: done=0, busy=0, err=0, clk_ena=0, sclr_n=1, sel_a=0, sel_b=0, shift_sel=0, pp_idx=0, state_out=3'b000.
- reset_a low mid-operation aborts immediately; no done pulse follows.
- Only clk and reset_a are edge-sensitive; start is a plain synchronous input.
- Outputs are Moore-decoded from the state and counter registers; no combinational path from start to any output.
- State encodings: IDLE=000, CLEAR=001, CALC=010, DONE=011, ERR=100. Remaining codes go to IDLE on the next clk.
- IDLE: all outputs at reset values. start=1 -> CLEAR; else stay.
- CLEAR (one cycle): sclr_n=0, clk_ena=1, busy=1, counter<=0. start=1 -> ERR; else -> CALC.
- CALC:
  - clk_ena=1, busy=1, pp_idx=counter.
  - sel_a = counter mod NCHUNK (inner loop); sel_b = counter / NCHUNK (outer loop); shift_sel = sel_a+sel_b.
  - Counter increments each cycle.
  - counter = NCHUNK*NCHUNK-1 -> DONE and counter wraps to 0.
  - start=1 in any CALC cycle has priority: -> ERR, counter<=0, and the accumulation for that cycle still occurs.
- DONE (one cycle): done=1, clk_ena=0. start=1 -> CLEAR (back-to-back, no idle cycle); else -> IDLE.
- ERR: err=1, clk_ena=0, sclr_n=1. start=1 -> CLEAR (restart); else stay.
- Latency: start sampled high in IDLE at edge 0 -> CLEAR in cycle 1, CALC in cycles 2..NCHUNK²+1, done=1 in cycle NCHUNK²+2.
  - NCHUNK=2: done in cycle 6.
- NCHUNK=1: exactly one CALC cycle, sel_a=sel_b=shift_sel=0.

Decomposition:
- Package mult_pkg: state encoding localparams (IDLE..ERR) and the 3-bit state width constant; shared with the datapath top and the bench.
- Sub-module mult_pp_sequencer:
  - Function: nested chunk counter parametrised by NCHUNK.
  - Inputs: clr, inc.
  - Outputs: sel_a, sel_b, shift_sel, pp_idx, last.
  - mult_control_seq instantiates it and keeps only the state register and output decode.

Test Plan:
- NCHUNK=2, reset, start pulse 1 cycle -> cycle 1 sclr_n=0; cycles 2-5 (sel_a,sel_b,shift_sel) = (0,0,0),(1,0,1),(0,1,1),(1,1,2); cycle 6 done=1; cycle 7 IDLE. With datapath model, A=0xA5, B=0x3C -> accumulator 0x26AC.
- NCHUNK=4 -> 16 CALC cycles; shift_sel sequence starts 0,1,2,3,1,2,... and ends at 6; done at cycle 18; 0xFFFF*0xFFFF = 0xFFFE0001 with datapath model.
- start reasserted in 2nd CALC cycle -> ERR next cycle, err=1, clk_ena=0, no done; start again -> CLEAR, then full sequence, done at cycle 6 after restart.
- start held high during DONE -> CLEAR the next cycle with sclr_n=0; second product correct; exactly one done per product.
- reset_a pulsed low mid-CALC -> outputs return to reset values asynchronously; state_out=000; no done afterwards until a new start.
- start held continuously high from IDLE -> CLEAR, then ERR, then CLEAR, alternating; done never asserted.
